crc_stream_engine: RTL and testbench

//  Parametrised streaming CRC generator/checker; successor of the fixed 8-bit CRC-32 block.

---
 rtl/crc_stream_engine_pkg.sv | 48 ++++
 rtl/crc_stream_engine_if.sv | 25 ++
 rtl/crc_stream_engine_byte_step.sv | 26 ++
 rtl/crc_stream_engine.sv | 149 ++++++++++++++
 tb/tb_crc_stream_engine.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/crc_stream_engine_pkg.sv
// Shared types, CRC preset constants and bit-reversal helper for the streaming CRC engine.
package crc_stream_engine_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_HOLD = 2'd2
   } crc_state_e;

   typedef struct packed {
      logic [5:0]  width;
      logic [31:0] poly;
      logic [31:0] init;
      logic [31:0] xorout;
      logic        refin;
      logic        refout;
      logic [31:0] residue;
   } crc_preset_t;

   localparam crc_preset_t CRC32_ETH = '{
      width: 6'd32, poly: 32'h04C11DB7, init: 32'hFFFFFFFF, xorout: 32'hFFFFFFFF,
      refin: 1'b1, refout: 1'b1, residue: 32'hC704DD7B};

   localparam crc_preset_t CRC16_CCITT_FALSE = '{
      width: 6'd16, poly: 32'h00001021, init: 32'h0000FFFF, xorout: 32'h00000000,
      refin: 1'b0, refout: 1'b0, residue: 32'h00000000};

   localparam crc_preset_t CRC16_IBM = '{
      width: 6'd16, poly: 32'h00008005, init: 32'h00000000, xorout: 32'h00000000,
      refin: 1'b1, refout: 1'b1, residue: 32'h00000000};

   localparam crc_preset_t CRC8 = '{
      width: 6'd8, poly: 32'h00000007, init: 32'h00000000, xorout: 32'h00000000,
      refin: 1'b0, refout: 1'b0, residue: 32'h00000000};

   // Reverses the low 'width' bits of value; bits above width come back as zero.
   function automatic logic [31:0] bitrev(input logic [31:0] value, input int width);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < 32; i++) begin
         if (i < width) begin
            r[i] = value[width-1-i];
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/crc_stream_engine_if.sv
// Beat input / result output handshake bundle for the streaming CRC engine.
interface crc_stream_engine_if #(
   parameter int DATA_W = 32,
   parameter int CRC_W  = 32
);
   logic                s_valid;
   logic                s_ready;
   logic [DATA_W-1:0]   s_data;
   logic [DATA_W/8-1:0] s_keep;
   logic                s_last;
   logic                m_valid;
   logic                m_ready;
   logic [CRC_W-1:0]    m_crc;
   logic                m_ok;

   modport master (
      output s_valid, s_data, s_keep, s_last, m_ready,
      input  s_ready, m_valid, m_crc, m_ok
   );

   modport slave (
      input  s_valid, s_data, s_keep, s_last, m_ready,
      output s_ready, m_valid, m_crc, m_ok
   );
endinterface

// File: rtl/crc_stream_engine_byte_step.sv
// One byte of CRC update on a normal-form (MSB-first) register, purely combinational.
module crc_byte_step #(
   parameter int          CRC_W = 32,
   parameter logic [31:0] POLY  = 32'h04C11DB7,
   parameter bit          REFIN = 1'b1
) (
   input  logic [CRC_W-1:0] crc_in,
   input  logic [7:0]       data_in,
   output logic [CRC_W-1:0] crc_out
);
   localparam logic [CRC_W-1:0] POLY_V = POLY[CRC_W-1:0];

   // Shift eight data bits through the LFSR, LSB first when input is reflected.
   always_comb begin
      logic [CRC_W-1:0] c;
      logic             din;
      logic             fb;
      c = crc_in;
      for (int i = 0; i < 8; i++) begin
         din = REFIN ? data_in[i] : data_in[7-i];
         fb  = c[CRC_W-1] ^ din;
         c   = {c[CRC_W-2:0], 1'b0} ^ (fb ? POLY_V : '0);
      end
      crc_out = c;
   end
endmodule

// File: rtl/crc_stream_engine.sv
// Streaming CRC generator/checker: byte-lane chain, frame FSM, result register and handshake.
module crc_stream_engine
   import crc_stream_engine_pkg::*;
#(
   parameter int          CRC_W   = 32,
   parameter logic [31:0] POLY    = CRC32_ETH.poly,
   parameter logic [31:0] INIT    = CRC32_ETH.init,
   parameter logic [31:0] XOROUT  = CRC32_ETH.xorout,
   parameter bit          REFIN   = 1'b1,
   parameter bit          REFOUT  = 1'b1,
   parameter logic [31:0] RESIDUE = CRC32_ETH.residue,
   parameter int          DATA_W  = 32
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   crc_stream_engine_if.slave bus
);
   localparam int LANES = DATA_W / 8;
   localparam int CNT_W = $clog2(LANES + 1);
   localparam logic [CRC_W-1:0] INIT_V    = INIT[CRC_W-1:0];
   localparam logic [CRC_W-1:0] XOROUT_V  = XOROUT[CRC_W-1:0];
   localparam logic [CRC_W-1:0] RESIDUE_V = RESIDUE[CRC_W-1:0];

   crc_state_e state_q, state_d;
   logic [CRC_W-1:0] crc_reg;
   logic [CRC_W-1:0] m_crc_q;
   logic             m_ok_q;
   logic [LANES:0][CRC_W-1:0] taps;
   logic [CNT_W-1:0] keep_cnt;
   logic [CRC_W-1:0] frame_crc;
   logic [CRC_W-1:0] out_crc;
   logic             hold;
   logic             ready;
   logic             accept;
   logic             take;

   assign hold   = (state_q == ST_HOLD);
   assign ready  = !hold || bus.m_ready;
   assign accept = bus.s_valid && ready && !clr;
   assign take   = hold && bus.m_ready;

   assign bus.s_ready = ready;
   assign bus.m_valid = hold;
   assign bus.m_crc   = m_crc_q;
   assign bus.m_ok    = m_ok_q;

   assign taps[0] = crc_reg;

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      crc_byte_step #(
         .CRC_W (CRC_W),
         .POLY  (POLY),
         .REFIN (REFIN)
      ) u_step (
         .crc_in  (taps[k]),
         .data_in (bus.s_data[8*k +: 8]),
         .crc_out (taps[k+1])
      );
   end

   // Kept lanes are contiguous from lane 0, so their count selects the chain tap.
   always_comb begin
      keep_cnt = '0;
      for (int i = 0; i < LANES; i++) begin
         if (bus.s_keep[i]) begin
            keep_cnt = keep_cnt + CNT_W'(1);
         end
      end
   end

   // Non-last beats use every lane; the last beat stops at the kept-lane tap.
   always_comb begin
      frame_crc = taps[LANES];
      if (bus.s_last) begin
         frame_crc = taps[keep_cnt];
      end
   end

   // Presentation form of the finished register: optional reversal, then final XOR.
   always_comb begin
      logic [31:0] ext;
      ext = '0;
      ext[CRC_W-1:0] = frame_crc;
      if (REFOUT) begin
         ext = bitrev(ext, CRC_W);
      end
      out_crc = ext[CRC_W-1:0] ^ XOROUT_V;
   end

   // Frame FSM next state; a result being taken can coincide with the next frame starting.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = bus.s_last ? ST_HOLD : ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (accept && bus.s_last) begin
               state_d = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (take) begin
               if (accept) begin
                  state_d = bus.s_last ? ST_HOLD : ST_BUSY;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (clr) begin
         state_d = ST_IDLE;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Running CRC register; reloads on frame end so the next frame can follow immediately.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         crc_reg <= INIT_V;
      end else if (accept) begin
         crc_reg <= bus.s_last ? INIT_V : frame_crc;
      end
   end

   // Result register captured on the last beat and held until replaced.
   always_ff @(posedge clk) begin
      if (rst) begin
         m_crc_q <= '0;
         m_ok_q  <= 1'b0;
      end else if (accept && bus.s_last) begin
         m_crc_q <= out_crc;
         m_ok_q  <= (frame_crc == RESIDUE_V);
      end
   end
endmodule

// File: tb/tb_crc_stream_engine.sv
// Directed self-checking bench: CRC-32 (32-bit beats) and CRC-16/CCITT-FALSE (16-bit beats).
module tb_crc_stream_engine;
   import crc_stream_engine_pkg::*;

   logic clk = 1'b0;
   logic rst;
   logic clr;
   int   checks = 0;
   int   errors = 0;

   crc_stream_engine_if #(.DATA_W(32), .CRC_W(32)) bus32();
   crc_stream_engine_if #(.DATA_W(16), .CRC_W(16)) bus16();

   crc_stream_engine dut32 (
      .clk (clk),
      .rst (rst),
      .clr (clr),
      .bus (bus32)
   );

   crc_stream_engine #(
      .CRC_W   (16),
      .POLY    (32'h00001021),
      .INIT    (32'h0000FFFF),
      .XOROUT  (32'h00000000),
      .REFIN   (1'b0),
      .REFOUT  (1'b0),
      .RESIDUE (32'h00000000),
      .DATA_W  (16)
   ) dut16 (
      .clk (clk),
      .rst (rst),
      .clr (clr),
      .bus (bus16)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [31:0] data, input logic [3:0] keep, input logic last);
      bus32.s_valid = 1'b1;
      bus32.s_data  = data;
      bus32.s_keep  = keep;
      bus32.s_last  = last;
      tick();
      bus32.s_valid = 1'b0;
      bus32.s_last  = 1'b0;
   endtask

   task automatic applyStimulus16(input logic [15:0] data, input logic [1:0] keep, input logic last);
      bus16.s_valid = 1'b1;
      bus16.s_data  = data;
      bus16.s_keep  = keep;
      bus16.s_last  = last;
      tick();
      bus16.s_valid = 1'b0;
      bus16.s_last  = 1'b0;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   initial begin
      rst = 1'b1;
      clr = 1'b0;
      bus32.s_valid = 1'b0; bus32.s_data = '0; bus32.s_keep = '0; bus32.s_last = 1'b0; bus32.m_ready = 1'b1;
      bus16.s_valid = 1'b0; bus16.s_data = '0; bus16.s_keep = '0; bus16.s_last = 1'b0; bus16.m_ready = 1'b1;
      #1;
      tick();
      tick();
      rst = 1'b0;

      $display("[TB] reset state");
      checkOutput("rst_m_valid", {31'd0, bus32.m_valid}, 32'd0);
      checkOutput("rst_m_crc", bus32.m_crc, 32'd0);
      checkOutput("rst_m_ok", {31'd0, bus32.m_ok}, 32'd0);
      checkOutput("rst_s_ready", {31'd0, bus32.s_ready}, 32'd1);
      checkOutput("rst16_m_valid", {31'd0, bus16.m_valid}, 32'd0);

      $display("[TB] CRC-32 of 123456789");
      applyStimulus(32'h34333231, 4'hF, 1'b0);
      checkOutput("t1_mid_m_valid", {31'd0, bus32.m_valid}, 32'd0);
      applyStimulus(32'h38373635, 4'hF, 1'b0);
      applyStimulus(32'h00000039, 4'h1, 1'b1);
      checkOutput("t1_m_valid", {31'd0, bus32.m_valid}, 32'd1);
      checkOutput("t1_m_crc", bus32.m_crc, 32'hCBF43926);
      tick();
      checkOutput("t1_taken", {31'd0, bus32.m_valid}, 32'd0);

      $display("[TB] residue check");
      applyStimulus(32'h34333231, 4'hF, 1'b0);
      applyStimulus(32'h38373635, 4'hF, 1'b0);
      applyStimulus(32'hF4392639, 4'hF, 1'b0);
      applyStimulus(32'h000000CB, 4'h1, 1'b1);
      checkOutput("t2_m_ok_good", {31'd0, bus32.m_ok}, 32'd1);
      checkOutput("t2_m_crc_magic", bus32.m_crc, 32'h2144DF1C);
      tick();
      applyStimulus(32'h34333230, 4'hF, 1'b0);
      applyStimulus(32'h38373635, 4'hF, 1'b0);
      applyStimulus(32'hF4392639, 4'hF, 1'b0);
      applyStimulus(32'h000000CB, 4'h1, 1'b1);
      checkOutput("t2_m_ok_bad", {31'd0, bus32.m_ok}, 32'd0);
      tick();

      $display("[TB] CRC-16/CCITT-FALSE");
      applyStimulus16(16'h3231, 2'b11, 1'b0);
      applyStimulus16(16'h3433, 2'b11, 1'b0);
      applyStimulus16(16'h3635, 2'b11, 1'b0);
      applyStimulus16(16'h3837, 2'b11, 1'b0);
      applyStimulus16(16'h0039, 2'b01, 1'b1);
      checkOutput("t3_m_valid", {31'd0, bus16.m_valid}, 32'd1);
      checkOutput("t3_m_crc", {16'd0, bus16.m_crc}, 32'h000029B1);
      tick();
      applyStimulus16(16'h3231, 2'b11, 1'b0);
      applyStimulus16(16'h3433, 2'b11, 1'b0);
      applyStimulus16(16'h3635, 2'b11, 1'b0);
      applyStimulus16(16'h3837, 2'b11, 1'b0);
      applyStimulus16(16'h2939, 2'b11, 1'b0);
      applyStimulus16(16'h00B1, 2'b01, 1'b1);
      checkOutput("t3_m_ok", {31'd0, bus16.m_ok}, 32'd1);
      tick();

      $display("[TB] empty last beat");
      applyStimulus(32'h34333231, 4'hF, 1'b0);
      applyStimulus(32'hDEADBEEF, 4'h0, 1'b1);
      checkOutput("t6_m_crc", bus32.m_crc, 32'h9BE3E0A3);
      tick();

      $display("[TB] backpressure hold");
      bus32.m_ready = 1'b0;
      applyStimulus(32'h34333231, 4'hF, 1'b1);
      checkOutput("t4_m_valid", {31'd0, bus32.m_valid}, 32'd1);
      bus32.s_valid = 1'b1;
      bus32.s_data  = 32'h38373635;
      bus32.s_keep  = 4'hF;
      bus32.s_last  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         checkOutput("t4_hold_s_ready", {31'd0, bus32.s_ready}, 32'd0);
         checkOutput("t4_hold_m_crc", bus32.m_crc, 32'h9BE3E0A3);
      end
      bus32.s_valid = 1'b0;
      bus32.s_last  = 1'b0;
      bus32.m_ready = 1'b1;
      tick();
      checkOutput("t4_released", {31'd0, bus32.m_valid}, 32'd0);

      $display("[TB] back-to-back frames");
      applyStimulus(32'h34333231, 4'hF, 1'b1);
      checkOutput("t4_a_crc", bus32.m_crc, 32'h9BE3E0A3);
      applyStimulus(32'h34333231, 4'hF, 1'b0);
      checkOutput("t4_b1_m_valid", {31'd0, bus32.m_valid}, 32'd0);
      applyStimulus(32'h38373635, 4'hF, 1'b0);
      applyStimulus(32'h00000039, 4'h1, 1'b1);
      checkOutput("t4_b_crc", bus32.m_crc, 32'hCBF43926);
      applyStimulus(32'h34333231, 4'hF, 1'b1);
      checkOutput("t4_a2_m_valid", {31'd0, bus32.m_valid}, 32'd1);
      checkOutput("t4_a2_crc", bus32.m_crc, 32'h9BE3E0A3);
      tick();

      $display("[TB] clear mid-frame");
      applyStimulus(32'h34333231, 4'hF, 1'b0);
      applyStimulus(32'h38373635, 4'hF, 1'b0);
      clr = 1'b1;
      applyStimulus(32'h00000039, 4'h1, 1'b1);
      clr = 1'b0;
      checkOutput("t5_clr_discard", {31'd0, bus32.m_valid}, 32'd0);
      applyStimulus(32'h34333231, 4'hF, 1'b0);
      applyStimulus(32'h38373635, 4'hF, 1'b0);
      applyStimulus(32'h00000039, 4'h1, 1'b1);
      checkOutput("t5_clr_crc", bus32.m_crc, 32'hCBF43926);
      bus32.m_ready = 1'b0;
      clr = 1'b1;
      tick();
      clr = 1'b0;
      bus32.m_ready = 1'b1;
      checkOutput("t5_clr_drops_result", {31'd0, bus32.m_valid}, 32'd0);

      $display("[TB] reset mid-frame");
      applyStimulus(32'h34333231, 4'hF, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkOutput("t5_rst_m_valid", {31'd0, bus32.m_valid}, 32'd0);
      checkOutput("t5_rst_m_crc", bus32.m_crc, 32'd0);
      checkOutput("t5_rst_s_ready", {31'd0, bus32.s_ready}, 32'd1);
      applyStimulus(32'h34333231, 4'hF, 1'b0);
      applyStimulus(32'h38373635, 4'hF, 1'b0);
      applyStimulus(32'h00000039, 4'h1, 1'b1);
      checkOutput("t5_rst_crc", bus32.m_crc, 32'hCBF43926);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
